// File: rtl/exp_series_engine.sv
// ============================================================================
// Module  : exp_series_engine
// Purpose : Fixed-point e^x via truncated Taylor series, start/done handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module exp_series_engine #(
    parameter int FRAC_W     = 16,
    parameter int TERMS      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [FRAC_W-1:0] x,
    output logic              busy,
    output logic              done,
    output logic [1:0]        intpart,
    output logic [FRAC_W-1:0] fracpart
);

    localparam int T_W = FRAC_W + 1;
    localparam int R_W = FRAC_W + 2;
    localparam int P_W = 2 * FRAC_W + 2;

    localparam logic [T_W-1:0] C_ONE_T = {1'b1, {FRAC_W{1'b0}}};
    localparam logic [R_W-1:0] C_ONE_R = {2'b01, {FRAC_W{1'b0}}};
    localparam logic [3:0]     C_TERMS = 4'(TERMS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_MUL_X = 3'd2,
        S_MUL_C = 3'd3,
        S_ACC   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [FRAC_W-1:0] r_x;
    logic [T_W-1:0]   r_t;
    logic [R_W-1:0]   r_r;
    logic [3:0]       r_k;
    logic [R_W-1:0]   r_out;

    logic [T_W-1:0]   w_coef [16];
    logic [T_W-1:0]   w_mul_b;
    logic [P_W-1:0]   w_prod;
    logic [T_W-1:0]   w_t_next;
    logic [R_W-1:0]   w_sum;
    logic             w_last;
    logic             w_unused_bits;

    // Reciprocal ROM: floor(2^FRAC_W / k); entry 0 is never addressed.
    for (genvar gi = 0; gi < 16; gi++) begin : g_rom
        if (gi == 0) begin : g_zero
            assign w_coef[gi] = '0;
        end else begin : g_div
            assign w_coef[gi] = T_W'((64'd1 << FRAC_W) / 64'(gi));
        end
    end

    // One shared multiplier serves both the x and 1/k steps.
    assign w_mul_b       = (r_state == S_MUL_X) ? {1'b0, r_x} : w_coef[r_k];
    assign w_prod        = P_W'(r_t) * P_W'(w_mul_b);
    assign w_t_next      = w_prod[2*FRAC_W:FRAC_W];
    assign w_unused_bits = ^{w_prod[P_W-1], w_prod[FRAC_W-1:0]};
    assign w_sum         = r_r + R_W'(r_t);
    assign w_last        = (r_k == C_TERMS) || ((EARLY_EXIT != 0) && (r_t == '0));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_INIT;
            S_INIT:  w_next = S_MUL_X;
            S_MUL_X: w_next = S_MUL_C;
            S_MUL_C: w_next = S_ACC;
            S_ACC:   w_next = w_last ? S_DONE : S_MUL_X;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_x   <= '0;
            r_t   <= '0;
            r_r   <= '0;
            r_k   <= '0;
            r_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_x <= x;
                end
                S_INIT: begin
                    r_t <= C_ONE_T;
                    r_r <= C_ONE_R;
                    r_k <= 4'd1;
                end
                S_MUL_X, S_MUL_C: begin
                    r_t <= w_t_next;
                end
                S_ACC: begin
                    r_r <= w_sum;
                    // Output register captures the final sum as DONE is entered.
                    if (w_last) begin
                        r_out <= w_sum;
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign intpart  = r_out[R_W-1:FRAC_W];
    assign fracpart = r_out[FRAC_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_exp_series_engine.sv
// ============================================================================
// Module  : tb_exp_series_engine
// Purpose : Directed bench for exp_series_engine, with and without early exit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_exp_series_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] x = 16'h0;

    logic        b0, d0, b1, d1;
    logic [1:0]  ip0, ip1;
    logic [15:0] fp0, fp1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    exp_series_engine #(.FRAC_W(16), .TERMS(8), .EARLY_EXIT(1)) dut_ee (
        .clk(clk), .rst(rst), .start(start), .x(x),
        .busy(b0), .done(d0), .intpart(ip0), .fracpart(fp0));

    exp_series_engine #(.FRAC_W(16), .TERMS(8), .EARLY_EXIT(0)) dut_ne (
        .clk(clk), .rst(rst), .start(start), .x(x),
        .busy(b1), .done(d1), .intpart(ip1), .fracpart(fp1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input logic [31:0] act,
                               input logic [31:0] lo, input logic [31:0] hi);
        vectors++;
        if ((^act === 1'bx) || act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h..%0h", name, act, lo, hi);
        end
    endtask

    // Series evaluated with plain integer arithmetic; n = terms executed.
    function automatic void exp_model(input logic [15:0] xv, input bit ee,
                                      output logic [17:0] res, output int n);
        longint t, r;
        t = 65536;
        r = 65536;
        n = 0;
        for (int k = 1; k <= 8; k++) begin
            t = (t * longint'(xv)) >> 16;
            t = (t * (65536 / k)) >> 16;
            r = r + t;
            n = k;
            if (ee && t == 0) break;
        end
        res = 18'(r);
    endfunction

    // Cycle-level model: instance 0 has early exit, instance 1 does not.
    bit          m_act [2];
    int          m_cnt [2];
    int          m_len [2];
    logic [17:0] m_res [2];
    logic [17:0] m_out [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_cnt[i] = 0; m_len[i] = 0; m_res[i] = '0; m_out[i] = '0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_act[i] = 0;
                m_cnt[i] = 0;
                m_out[i] = '0;
            end else if (m_act[i]) begin
                if (m_cnt[i] == m_len[i]) begin
                    m_act[i] = 0;
                end else begin
                    m_cnt[i]++;
                    if (m_cnt[i] == m_len[i]) m_out[i] = m_res[i];
                end
            end else if (start) begin
                int n;
                exp_model(x, (i == 0), m_res[i], n);
                m_len[i] = 3 * n + 2;
                m_act[i] = 1;
                m_cnt[i] = 1;
            end
        end
    end

    always @(negedge clk) begin
        check("busy_ee", 32'(b0), 32'(m_act[0]));
        check("done_ee", 32'(d0), 32'(m_act[0] && m_cnt[0] == m_len[0]));
        check("res_ee",  32'({ip0, fp0}), 32'(m_out[0]));
        check("busy_ne", 32'(b1), 32'(m_act[1]));
        check("done_ne", 32'(d1), 32'(m_act[1] && m_cnt[1] == m_len[1]));
        check("res_ne",  32'({ip1, fp1}), 32'(m_out[1]));
    end

    task automatic run(input logic [15:0] xv, input bit disturb, input int rst_at,
                       output int l0, output int l1);
        l0 = -1;
        l1 = -1;
        @(negedge clk);
        start = 1'b1;
        x     = xv;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (d0 === 1'b1) l0 = c;
            if (d1 === 1'b1) l1 = c;
            if (rst_at > 0 && c == rst_at + 1) begin
                check("rst_busy_ee", 32'(b0), 32'd0);
                check("rst_busy_ne", 32'(b1), 32'd0);
                check("rst_out_ne", 32'({ip1, fp1}), 32'd0);
                break;
            end
            rst = (rst_at == c) ? 1'b0 : 1'b1;
            if (disturb && (c == 3 || c == 12)) begin
                start = 1'b1;
                x     = 16'h1234;
            end else begin
                start = 1'b0;
            end
            if (l0 >= 0 && l1 >= 0) break;
            @(negedge clk);
        end
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int l0, l1;
        rst   = 1'b0;
        start = 1'b1;
        x     = 16'hFFFF;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(b1), 32'd0);
        check("reset_done", 32'(d1), 32'd0);
        check("reset_int",  32'(ip1), 32'd0);
        check("reset_frac", 32'(fp0), 32'd0);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);

        run(16'h0000, 1'b0, 0, l0, l1);
        check("x0_lat_ee", 32'(l0), 32'd5);
        check("x0_lat_ne", 32'(l1), 32'd26);
        check("x0_res_ee", 32'({ip0, fp0}), 32'h10000);
        check("x0_res_ne", 32'({ip1, fp1}), 32'h10000);

        run(16'h8000, 1'b0, 0, l0, l1);
        check("half_lat_ne", 32'(l1), 32'd26);
        check("half_lat_ee", 32'(l0), 32'd23);
        check("half_int", 32'(ip1), 32'd1);
        check_range("half_frac", 32'(fp1), 32'hA600, 32'hA612);

        run(16'hFFFF, 1'b0, 0, l0, l1);
        check("max_int", 32'(ip1), 32'd2);
        check_range("max_frac", 32'(fp1), 32'hB7C0, 32'hB7DF);
        repeat (10) @(negedge clk);
        check("max_hold_int", 32'(ip1), 32'd2);
        check_range("max_hold_frac", 32'(fp1), 32'hB7C0, 32'hB7DF);

        run(16'h8000, 1'b1, 0, l0, l1);
        check("dist_lat_ne", 32'(l1), 32'd26);
        check("dist_lat_ee", 32'(l0), 32'd23);
        check_range("dist_frac", 32'(fp1), 32'hA600, 32'hA612);

        run(16'h8000, 1'b0, 10, l0, l1);
        check("abort_no_done", 32'(l1), 32'hFFFFFFFF);

        run(16'h4000, 1'b0, 0, l0, l1);
        check("q_lat_ne", 32'(l1), 32'd26);
        check("q_int", 32'(ip1), 32'd1);
        check_range("q_frac", 32'(fp1), 32'h4890, 32'h48B6);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
